// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the main-RAM port arbiter.
// Purpose : FSM state encoding, requester ids and default timing parameters
//           used by mem_port_arbiter.
// Contents: arb_state_e   - IDLE / ACCESS / DONE
//           requester_e   - RQ_IF (instruction fetch) / RQ_MEM (data stage)
//           DEF_*         - default parameter values
//           streak_next() - saturating increment of the data-grant streak
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W          = 22;
  localparam int DEF_WAIT_CYCLES     = 2;
  localparam int DEF_MAX_DATA_STREAK = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    RQ_IF  = 1'b0,
    RQ_MEM = 1'b1
  } requester_e;

  // Saturating +1 on a 32-bit container; caller truncates to its own width.
  function automatic int unsigned streak_next(input int unsigned cur, input int unsigned max_val);
    if (cur >= max_val) begin
      return max_val;
    end else begin
      return cur + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Purpose : shares the single-ported, multi-cycle main RAM between instruction
//           fetch (read-only) and the MEM stage (read/write). Accesses are
//           serialised IDLE -> ACCESS (WAIT_CYCLES clocks) -> DONE, with a
//           one-cycle ack per access. MEM normally wins collisions, but after
//           MAX_DATA_STREAK consecutive MEM grants with fetch waiting, fetch
//           is forced through.
// Ports   : clk, rst (async, active-low)
//           if_req/if_addr        -> if_rdata/if_ack     fetch side
//           mem_req/we/addr/be/wdata -> mem_rdata/mem_ack data side
//           ram_addr/oe/we/be/wdata -> RAM, ram_rdata <- RAM
//           All outputs are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int WAIT_CYCLES     = DEF_WAIT_CYCLES,
  parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_be,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_e          state_q;
  requester_e          winner_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                ram_oe_q;
  logic                ram_we_q;
  logic [3:0]          ram_be_q;
  logic [31:0]         ram_wdata_q;
  logic [31:0]         if_rdata_q;
  logic [31:0]         mem_rdata_q;
  logic                if_ack_q;
  logic                mem_ack_q;

  logic grant_valid;
  logic grant_if;
  logic grant_rd;

  // Arbitration decision in IDLE: MEM wins collisions until the streak limit.
  always_comb begin
    grant_valid = 1'b0;
    grant_if    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (if_req && mem_req) begin
        grant_valid = 1'b1;
        grant_if    = (streak_q == STREAK_MAX);
      end else if (if_req) begin
        grant_valid = 1'b1;
        grant_if    = 1'b1;
      end else if (mem_req) begin
        grant_valid = 1'b1;
        grant_if    = 1'b0;
      end else begin
        grant_valid = 1'b0;
        grant_if    = 1'b0;
      end
    end else begin
      grant_valid = 1'b0;
      grant_if    = 1'b0;
    end
    // Fetches are always reads.
    grant_rd = grant_if | ~mem_we;
  end

  // Streak only counts MEM grants that left a fetch waiting.
  always_comb begin
    streak_d = streak_q;
    if (state_q == ST_IDLE) begin
      if (!if_req) begin
        streak_d = {STREAK_W{1'b0}};
      end else if (grant_if) begin
        streak_d = {STREAK_W{1'b0}};
      end else if (mem_req) begin
        streak_d = STREAK_W'(streak_next(32'(streak_q), 32'(MAX_DATA_STREAK)));
      end else begin
        streak_d = streak_q;
      end
    end else begin
      streak_d = streak_q;
    end
  end

  // Arbiter FSM with registered RAM strobes, acks and read-data holding regs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      winner_q    <= RQ_IF;
      cnt_q       <= {CNT_W{1'b0}};
      streak_q    <= {STREAK_W{1'b0}};
      ram_addr_q  <= {ADDR_W{1'b0}};
      ram_oe_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_be_q    <= 4'b0000;
      ram_wdata_q <= 32'h0000_0000;
      if_rdata_q  <= 32'h0000_0000;
      mem_rdata_q <= 32'h0000_0000;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      streak_q  <= streak_d;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            // Latch everything now; requester inputs are not looked at again.
            state_q     <= ST_ACCESS;
            cnt_q       <= CNT_LAST;
            winner_q    <= grant_if ? RQ_IF : RQ_MEM;
            ram_addr_q  <= grant_if ? if_addr : mem_addr;
            ram_oe_q    <= grant_rd;
            ram_we_q    <= ~grant_rd;
            ram_be_q    <= grant_rd ? 4'b1111 : mem_be;
            ram_wdata_q <= grant_rd ? 32'h0000_0000 : mem_wdata;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            if (ram_oe_q) begin
              if (winner_q == RQ_IF) begin
                if_rdata_q <= ram_rdata;
              end else begin
                mem_rdata_q <= ram_rdata;
              end
            end else begin
              if_rdata_q <= if_rdata_q;
            end
            state_q     <= ST_DONE;
            if_ack_q    <= (winner_q == RQ_IF);
            mem_ack_q   <= (winner_q == RQ_MEM);
            ram_addr_q  <= {ADDR_W{1'b0}};
            ram_oe_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= 4'b0000;
            ram_wdata_q <= 32'h0000_0000;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          ram_oe_q    <= 1'b0;
          ram_we_q    <= 1'b0;
          ram_be_q    <= 4'b0000;
          ram_wdata_q <= 32'h0000_0000;
          ram_addr_q  <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign ram_addr  = ram_addr_q;
  assign ram_oe    = ram_oe_q;
  assign ram_we    = ram_we_q;
  assign ram_be    = ram_be_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small byte-enabled RAM model.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 22;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_oe;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic [31:0] ram_mem [0:255];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .WAIT_CYCLES(2),
    .MAX_DATA_STREAK(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ram_addr(ram_addr), .ram_oe(ram_oe), .ram_we(ram_we), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = ram_oe ? ram_mem[ram_addr[7:0]] : 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the RAM model commits a pending write on the edge.
  task automatic tick();
    logic        we_s;
    logic [7:0]  a_s;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    we_s = ram_we; a_s = ram_addr[7:0]; be_s = ram_be; wd_s = ram_wdata;
    @(posedge clk);
    if (we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) ram_mem[a_s][b*8 +: 8] = wd_s[b*8 +: 8];
      end
    end
    #1;
  endtask

  initial begin
    int n;
    logic order [0:7];
    logic exp_order [0:7];

    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0;
    ram_mem[8'h10] = 32'hDEADBEEF;
    ram_mem[8'h20] = 32'hAABBCCDD;
    ram_mem[8'h30] = 32'hCAFEF00D;
    ram_mem[8'h31] = 32'h31313131;
    ram_mem[8'h40] = 32'h0BADF00D;
    exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    exp_order[4] = 1'b0; exp_order[5] = 1'b0; exp_order[6] = 1'b0; exp_order[7] = 1'b1;
    for (int i = 0; i < 8; i++) order[i] = 1'b0;

    // Reset held with a fetch pending
    rst = 1'b0; if_req = 1'b1; if_addr = 22'h10;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 22'h0; mem_be = 4'h0; mem_wdata = 32'h0;
    tick(); tick(); tick();
    chk("rst_ram_oe", 64'(ram_oe), 64'h0);
    chk("rst_ram_we", 64'(ram_we), 64'h0);
    chk("rst_ram_addr", 64'(ram_addr), 64'h0);
    chk("rst_ram_be", 64'(ram_be), 64'h0);
    chk("rst_acks", 64'({if_ack, mem_ack}), 64'h0);
    chk("rst_rdata", 64'({if_rdata, mem_rdata}), 64'h0);

    // Release: fetch of 0x10 granted on the next edge
    rst = 1'b1;
    tick();  // cycle 1
    chk("if_c1_oe", 64'(ram_oe), 64'h1);
    chk("if_c1_addr", 64'(ram_addr), 64'h10);
    chk("if_c1_be", 64'(ram_be), 64'hF);
    chk("if_c1_we", 64'(ram_we), 64'h0);
    tick();  // cycle 2
    chk("if_c2_oe", 64'(ram_oe), 64'h1);
    chk("if_c2_ack", 64'(if_ack), 64'h0);
    tick();  // cycle 3
    chk("if_c3_ack", 64'(if_ack), 64'h1);
    chk("if_c3_rdata", 64'(if_rdata), 64'hDEADBEEF);
    chk("if_c3_oe", 64'(ram_oe), 64'h0);
    chk("if_c3_mem_ack", 64'(mem_ack), 64'h0);
    tick();  // cycle 4, idle
    if_req = 1'b0;
    chk("if_c4_ack", 64'(if_ack), 64'h0);
    chk("if_c4_hold", 64'(if_rdata), 64'hDEADBEEF);
    tick();
    chk("idle_oe", 64'(ram_oe), 64'h0);

    // Collision: both requesting continuously
    if_req = 1'b1; if_addr = 22'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 22'h30;
    n = 0;
    for (int c = 0; c < 80 && n < 8; c++) begin
      tick();
      chk("ack_exclusive", 64'(if_ack & mem_ack), 64'h0);
      chk("strobe_exclusive", 64'(ram_oe & ram_we), 64'h0);
      if (if_ack) begin
        order[n] = 1'b1; n++;
      end else if (mem_ack) begin
        order[n] = 1'b0; n++;
      end
    end
    chk("coll_count", 64'(n), 64'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("coll_grant%0d_is_if", i), 64'(order[i]), 64'(exp_order[i]));
    chk("coll_mem_rdata", 64'(mem_rdata), 64'hCAFEF00D);
    if_req = 1'b0; mem_req = 1'b0;
    tick(); tick();

    // MEM partial write of 0x20
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 22'h20; mem_be = 4'b0011; mem_wdata = 32'h12345678;
    tick();  // cycle 1
    chk("wr_c1_we", 64'(ram_we), 64'h1);
    chk("wr_c1_oe", 64'(ram_oe), 64'h0);
    chk("wr_c1_be", 64'(ram_be), 64'h3);
    chk("wr_c1_wdata", 64'(ram_wdata), 64'h12345678);
    chk("wr_c1_addr", 64'(ram_addr), 64'h20);
    tick();  // cycle 2
    chk("wr_c2_we", 64'(ram_we), 64'h1);
    tick();  // cycle 3
    chk("wr_c3_ack", 64'(mem_ack), 64'h1);
    chk("wr_c3_we", 64'(ram_we), 64'h0);
    chk("wr_ram_word", 64'(ram_mem[8'h20]), 64'hAABB5678);
    chk("wr_rdata_kept", 64'(mem_rdata), 64'hCAFEF00D);
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    tick();

    // Fetch withdrawn after grant while MEM starts requesting
    if_req = 1'b1; if_addr = 22'h40;
    tick();  // cycle 1
    chk("wd_c1_addr", 64'(ram_addr), 64'h40);
    if_req = 1'b0; if_addr = 22'h99;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 22'h31;
    tick();  // cycle 2
    chk("wd_c2_addr_latched", 64'(ram_addr), 64'h40);
    tick();  // cycle 3
    chk("wd_c3_if_ack", 64'(if_ack), 64'h1);
    chk("wd_c3_if_rdata", 64'(if_rdata), 64'h0BADF00D);
    chk("wd_c3_mem_ack", 64'(mem_ack), 64'h0);
    tick();  // cycle 4
    chk("wd_c4_if_ack_once", 64'(if_ack), 64'h0);
    tick();  // cycle 5
    chk("wd_c5_mem_oe", 64'(ram_oe), 64'h1);
    chk("wd_c5_mem_addr", 64'(ram_addr), 64'h31);
    tick(); tick();  // cycle 7
    chk("wd_c7_mem_ack", 64'(mem_ack), 64'h1);
    chk("wd_c7_mem_rdata", 64'(mem_rdata), 64'h31313131);
    chk("wd_c7_if_ack", 64'(if_ack), 64'h0);
    tick();
    mem_req = 1'b0;
    tick();

    // Reset in the middle of a write
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 22'h50; mem_be = 4'hF; mem_wdata = 32'h55AA55AA;
    tick();  // cycle 1
    chk("rw_c1_we", 64'(ram_we), 64'h1);
    #1 rst = 1'b0;
    #1;
    chk("rw_async_we", 64'(ram_we), 64'h0);
    chk("rw_async_addr", 64'(ram_addr), 64'h0);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    chk("rw_no_ack", 64'(mem_ack), 64'h0);
    rst = 1'b1;
    tick();
    chk("rw_idle_oe", 64'(ram_oe), 64'h0);
    chk("rw_idle_we", 64'(ram_we), 64'h0);
    tick();
    chk("rw_no_ack_after", 64'(mem_ack), 64'h0);
    chk("rw_ram_untouched", 64'(ram_mem[8'h50]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
